// File: rtl/pixel_filter_pkg.sv
// pixel_filter_pkg
//   Shared definitions for the pixel filter pipeline: the internal filter
//   mode enum, the 3-bit selection decoder, the fixed colour weights and
//   the gain width.
package pixel_filter_pkg;

  typedef enum logic [2:0] {
    MODE_GRAY   = 3'd0,
    MODE_PINK   = 3'd1,
    MODE_PASS   = 3'd2,
    MODE_INVERT = 3'd3,
    MODE_THRESH = 3'd4
  } mode_e;

  // Gain never exceeds 63, so six bits hold it.
  localparam int unsigned GAIN_W = 6;

  // Gray weights sum to 256 so the >>8 result never exceeds the channel range.
  localparam int unsigned GRAY_WR    = 77;
  localparam int unsigned GRAY_WG    = 150;
  localparam int unsigned GRAY_WB    = 29;
  localparam int unsigned GRAY_SHIFT = 8;

  localparam int unsigned PINK_WR    = 120;
  localparam int unsigned PINK_WG    = 60;
  localparam int unsigned PINK_WB    = 50;
  localparam int unsigned PINK_SHIFT = 14;

  function automatic mode_e decode_mode(input logic [2:0] sel);
    case (sel)
      3'd1:       return MODE_PINK;
      3'd3, 3'd7: return MODE_PASS;
      3'd5:       return MODE_INVERT;
      3'd6:       return MODE_THRESH;
      default:    return MODE_GRAY;
    endcase
  endfunction

endpackage

// File: rtl/pixel_filter_pipe_pitch_smoother.sv
// pitch_smoother
//   Caps the raw pitch into [PITCH_MIN, PITCH_MAX] and runs a first-order
//   IIR on each strobe. Small steps snap straight to the target so the
//   filter cannot stall short of it.
//   Ports:
//     clk, rst_n       clock, async active-low reset
//     pitch_in_i       raw unsigned pitch
//     pitch_valid_i    one-cycle strobe qualifying pitch_in_i
//     p_s_o            smoothed pitch, always inside the cap range
module pitch_smoother
  import pixel_filter_pkg::*;
#(
  parameter int unsigned PITCH_W      = 30,
  parameter int unsigned PITCH_MIN    = 10,
  parameter int unsigned PITCH_MAX    = 63,
  parameter int unsigned SMOOTH_SHIFT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PITCH_W-1:0] pitch_in_i,
  input  logic               pitch_valid_i,
  output logic [GAIN_W-1:0]  p_s_o
);

  localparam logic [PITCH_W-1:0]  MIN_W = PITCH_W'(PITCH_MIN);
  localparam logic [PITCH_W-1:0]  MAX_W = PITCH_W'(PITCH_MAX);
  localparam logic [GAIN_W+1:0]   SNAP  = (GAIN_W+2)'(1 << SMOOTH_SHIFT);

  logic [GAIN_W-1:0]        cap;
  logic [GAIN_W-1:0]        p_s_q, p_s_d;
  logic signed [GAIN_W+1:0] diff, step, moved;
  logic [GAIN_W+1:0]        diff_abs;

  always_comb begin
    if (pitch_in_i < MIN_W)      cap = GAIN_W'(PITCH_MIN);
    else if (pitch_in_i > MAX_W) cap = GAIN_W'(PITCH_MAX);
    else                         cap = pitch_in_i[GAIN_W-1:0];

    // Two guard bits keep the signed difference of two 6-bit values exact.
    diff     = $signed({2'b00, cap}) - $signed({2'b00, p_s_q});
    diff_abs = diff[GAIN_W+1] ? $unsigned(-diff) : $unsigned(diff);
    step     = diff >>> SMOOTH_SHIFT;
    // The step lies between 0 and diff, so the result stays between
    // p_s and cap and therefore inside the cap range.
    moved    = $signed({2'b00, p_s_q}) + step;

    p_s_d = p_s_q;
    if (pitch_valid_i) begin
      if (diff_abs < SNAP) p_s_d = cap;
      else                 p_s_d = GAIN_W'(moved);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p_s_q <= GAIN_W'(PITCH_MIN);
    else        p_s_q <= p_s_d;
  end

  assign p_s_o = p_s_q;

endmodule

// File: rtl/pixel_filter_pipe.sv
// pixel_filter_pipe
//   Three-stage streaming per-pixel colour filter with full backpressure.
//   Mode and gain are latched on each accepted SOP beat and travel with
//   every beat so in-flight pixels are never affected by a new frame.
//   Ports:
//     clk, rst_n                    clock, async active-low reset
//     filter_selection              requested mode, sampled on accepted SOP
//     pitch_in, pitch_valid         raw pitch and its strobe
//     s_data/s_valid/s_ready        input pixel stream {R,G,B}
//     s_sop, s_eop                  input frame markers
//     m_data/m_valid/m_ready        output pixel stream {R,G,B}
//     m_sop, m_eop                  output frame markers
module pixel_filter_pipe
  import pixel_filter_pkg::*;
#(
  parameter int unsigned IN_BITS      = 4,
  parameter int unsigned OUT_BITS     = 10,
  parameter int unsigned PITCH_W      = 30,
  parameter int unsigned PITCH_MIN    = 10,
  parameter int unsigned PITCH_MAX    = 63,
  parameter int unsigned SMOOTH_SHIFT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            filter_selection,
  input  logic [PITCH_W-1:0]    pitch_in,
  input  logic                  pitch_valid,
  input  logic [3*IN_BITS-1:0]  s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_sop,
  input  logic                  s_eop,
  output logic [3*OUT_BITS-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_sop,
  output logic                  m_eop
);

  localparam int unsigned SW = OUT_BITS + 8;
  localparam int unsigned PW = SW + GAIN_W;
  localparam logic [OUT_BITS-1:0] CH_MAX = '1;

  // {c, c, zeros}: replicate the channel into the top of the output width.
  function automatic logic [OUT_BITS-1:0] expand(input logic [IN_BITS-1:0] c);
    logic [OUT_BITS-1:0] w;
    w = OUT_BITS'(c);
    return (w << (OUT_BITS - IN_BITS)) | (w << (OUT_BITS - 2*IN_BITS));
  endfunction

  logic              adv, accept;
  logic [GAIN_W-1:0] p_s;
  mode_e             mode_q, beat_mode;
  logic [GAIN_W-1:0] gain_q, beat_gain;

  logic                s1_valid_q, s1_sop_q, s1_eop_q;
  logic [OUT_BITS-1:0] s1_r_q, s1_g_q, s1_b_q;
  mode_e               s1_mode_q;
  logic [GAIN_W-1:0]   s1_gain_q;

  logic                s2_valid_q, s2_sop_q, s2_eop_q;
  logic [OUT_BITS-1:0] s2_r_q, s2_g_q, s2_b_q;
  mode_e               s2_mode_q;
  logic [SW-1:0]       s2_gsum_q, gsum_d, psum_d;
  logic [PW-1:0]       s2_prod_q, prod_d, pink_full;

  logic                  m_valid_q, m_sop_q, m_eop_q;
  logic [3*OUT_BITS-1:0] m_data_q, m_data_d;
  logic [OUT_BITS-1:0]   gray, pink;

  pitch_smoother #(
    .PITCH_W      (PITCH_W),
    .PITCH_MIN    (PITCH_MIN),
    .PITCH_MAX    (PITCH_MAX),
    .SMOOTH_SHIFT (SMOOTH_SHIFT)
  ) u_pitch (
    .clk           (clk),
    .rst_n         (rst_n),
    .pitch_in_i    (pitch_in),
    .pitch_valid_i (pitch_valid),
    .p_s_o         (p_s)
  );

  assign adv     = !m_valid_q || m_ready;
  assign s_ready = adv;
  assign accept  = s_valid && adv;

  // The SOP beat itself already uses the newly selected mode and gain.
  assign beat_mode = s_sop ? decode_mode(filter_selection) : mode_q;
  assign beat_gain = s_sop ? p_s : gain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_GRAY;
      gain_q <= GAIN_W'(PITCH_MIN);
    end else if (accept && s_sop) begin
      mode_q <= beat_mode;
      gain_q <= beat_gain;
    end
  end

  // S1: expand and register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sop_q   <= 1'b0;
      s1_eop_q   <= 1'b0;
      s1_r_q     <= '0;
      s1_g_q     <= '0;
      s1_b_q     <= '0;
      s1_mode_q  <= MODE_GRAY;
      s1_gain_q  <= '0;
    end else if (adv) begin
      s1_valid_q <= accept;
      s1_sop_q   <= s_sop;
      s1_eop_q   <= s_eop;
      s1_r_q     <= expand(s_data[3*IN_BITS-1 -: IN_BITS]);
      s1_g_q     <= expand(s_data[2*IN_BITS-1 -: IN_BITS]);
      s1_b_q     <= expand(s_data[IN_BITS-1:0]);
      s1_mode_q  <= beat_mode;
      s1_gain_q  <= beat_gain;
    end
  end

  // S2: weighted sums and gain multiply.
  always_comb begin
    gsum_d = SW'(GRAY_WR) * SW'(s1_r_q) + SW'(GRAY_WG) * SW'(s1_g_q)
           + SW'(GRAY_WB) * SW'(s1_b_q);
    psum_d = SW'(PINK_WR) * SW'(s1_r_q) + SW'(PINK_WG) * SW'(s1_g_q)
           + SW'(PINK_WB) * SW'(s1_b_q);
    prod_d = PW'(psum_d) * PW'(s1_gain_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_sop_q   <= 1'b0;
      s2_eop_q   <= 1'b0;
      s2_r_q     <= '0;
      s2_g_q     <= '0;
      s2_b_q     <= '0;
      s2_mode_q  <= MODE_GRAY;
      s2_gsum_q  <= '0;
      s2_prod_q  <= '0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      s2_sop_q   <= s1_sop_q;
      s2_eop_q   <= s1_eop_q;
      s2_r_q     <= s1_r_q;
      s2_g_q     <= s1_g_q;
      s2_b_q     <= s1_b_q;
      s2_mode_q  <= s1_mode_q;
      s2_gsum_q  <= gsum_d;
      s2_prod_q  <= prod_d;
    end
  end

  // S3: shift, saturate, mode select.
  always_comb begin
    gray      = OUT_BITS'(s2_gsum_q >> GRAY_SHIFT);
    pink_full = s2_prod_q >> PINK_SHIFT;
    pink      = (pink_full > PW'(CH_MAX)) ? CH_MAX : pink_full[OUT_BITS-1:0];
    case (s2_mode_q)
      MODE_PINK:   m_data_d = {pink, pink >> 2, pink >> 1};
      MODE_PASS:   m_data_d = {s2_r_q, s2_g_q, s2_b_q};
      MODE_INVERT: m_data_d = {CH_MAX - s2_r_q, CH_MAX - s2_g_q, CH_MAX - s2_b_q};
      MODE_THRESH: m_data_d = gray[OUT_BITS-1] ? {3{CH_MAX}} : '0;
      default:     m_data_d = {3{gray}};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_sop_q   <= 1'b0;
      m_eop_q   <= 1'b0;
      m_data_q  <= '0;
    end else if (adv) begin
      m_valid_q <= s2_valid_q;
      m_sop_q   <= s2_sop_q;
      m_eop_q   <= s2_eop_q;
      m_data_q  <= m_data_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_sop   = m_sop_q;
  assign m_eop   = m_eop_q;
  assign m_data  = m_data_q;

endmodule

// File: tb/tb_pixel_filter_pipe.sv
// tb_pixel_filter_pipe
//   Scoreboard bench: every accepted input beat pushes the expected output
//   (from an arithmetic model of the filter, frame latch and pitch IIR);
//   the monitor pops and compares on every output transfer.
module tb_pixel_filter_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  filter_selection = '0;
  logic [29:0] pitch_in = '0;
  logic        pitch_valid = 1'b0;
  logic [11:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_sop = 1'b0;
  logic        s_eop = 1'b0;
  logic [29:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_sop;
  logic        m_eop;

  int total = 0;
  int bad   = 0;
  int pops  = 0;

  typedef struct {
    logic [29:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t exp_q[$];

  int m_mode = 0;
  int m_gain = 10;
  int m_ps   = 10;

  always #5 clk = ~clk;

  pixel_filter_pipe #(
    .IN_BITS(4), .OUT_BITS(10), .PITCH_W(30),
    .PITCH_MIN(10), .PITCH_MAX(63), .SMOOTH_SHIFT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .filter_selection(filter_selection),
    .pitch_in(pitch_in), .pitch_valid(pitch_valid),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_sop(s_sop), .s_eop(s_eop),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_sop(m_sop), .m_eop(m_eop)
  );

  function automatic logic [29:0] model_pixel(input logic [11:0] px, input int mode, input int gain);
    int er, eg, eb, g, p;
    // A 4-bit channel c expands to c*64 + c*4.
    er = int'(px[11:8]) * 68;
    eg = int'(px[7:4]) * 68;
    eb = int'(px[3:0]) * 68;
    g  = (77*er + 150*eg + 29*eb) / 256;
    case (mode)
      1: begin
        p = ((120*er + 60*eg + 50*eb) * gain) / 16384;
        if (p > 1023) p = 1023;
        return {10'(p), 10'(p/4), 10'(p/2)};
      end
      3, 7: return {10'(er), 10'(eg), 10'(eb)};
      5:    return {10'(1023-er), 10'(1023-eg), 10'(1023-eb)};
      6:    return (g >= 512) ? {3{10'd1023}} : 30'd0;
      default: return {10'(g), 10'(g), 10'(g)};
    endcase
  endfunction

  function automatic int model_smooth(input int ps, input logic [29:0] raw);
    int cap, d;
    if (raw < 30'd10)      cap = 10;
    else if (raw > 30'd63) cap = 63;
    else                   cap = int'(raw);
    d = cap - ps;
    if (d > -4 && d < 4) return cap;
    if (d >= 0) return ps + d / 4;
    return ps - (-d + 3) / 4;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_mode = 0;
      m_gain = 10;
      m_ps   = 10;
    end else begin
      if (s_valid && s_ready) begin
        beat_t b;
        if (s_sop) begin
          m_mode = int'(filter_selection);
          m_gain = m_ps;
        end
        b.data = model_pixel(s_data, m_mode, m_gain);
        b.sop  = s_sop;
        b.eop  = s_eop;
        exp_q.push_back(b);
      end
      if (pitch_valid) m_ps = model_smooth(m_ps, pitch_in);
    end
  end

  logic        stall_prev = 1'b0;
  logic [31:0] held;

  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if (s_ready !== (!m_valid || m_ready)) begin
        bad++;
        $display("FAIL s_ready_rule: got %b want %b", s_ready, (!m_valid || m_ready));
      end
      if (stall_prev) begin
        total++;
        if ({m_valid, m_data, m_sop, m_eop} !== {1'b1, held[31:0]}) begin
          bad++;
          $display("FAIL stall_hold: got %h want %h", {m_data, m_sop, m_eop}, held);
        end
      end
      if (m_valid && m_ready) begin
        total++;
        pops++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output: got %h with empty scoreboard", m_data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if ({m_data, m_sop, m_eop} !== {e.data, e.sop, e.eop}) begin
            bad++;
            $display("FAIL pixel: got data=%h sop=%b eop=%b want data=%h sop=%b eop=%b",
                     m_data, m_sop, m_eop, e.data, e.sop, e.eop);
          end
        end
      end
      stall_prev = m_valid && !m_ready;
      held = {m_data, m_sop, m_eop};
    end else begin
      stall_prev = 1'b0;
    end
  end

  // All tasks start and end at posedge+1.
  task automatic send(input logic [11:0] px, input logic sop, input logic eop, input logic [2:0] sel);
    bit ok;
    ok = 1'b0;
    s_data = px; s_sop = sop; s_eop = eop; filter_selection = sel; s_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout: got s_ready=0 for 200 cycles want 1");
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
  endtask

  task automatic strobe(input int v);
    pitch_in = 30'(v); pitch_valid = 1'b1;
    @(posedge clk); #1;
    pitch_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_valid) begin
        done = 1'b1;
        break;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL drain_%s: got %0d pending want 0", name, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_out(input string name, input logic [29:0] want);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_valid) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen || m_data !== want || m_sop !== 1'b1) begin
      bad++;
      $display("FAIL %s: got valid=%b data=%h sop=%b want data=%h sop=1", name, seen, m_data, m_sop, want);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #13;
    total += 4;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    if (m_data !== 30'd0) begin bad++; $display("FAIL reset_m_data: got %h want 0", m_data); end
    if ({m_sop, m_eop} !== 2'b00) begin bad++; $display("FAIL reset_markers: got %b want 00", {m_sop, m_eop}); end
    if (int'(dut.u_pitch.p_s_q) != 10) begin bad++; $display("FAIL reset_p_s: got %0d want 10", dut.u_pitch.p_s_q); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_gray();
    send(12'hFFF, 1'b1, 1'b1, 3'd0);
    wait_out("gray_white", {10'd1020, 10'd1020, 10'd1020});
    drain("gray_single");
    for (int i = 0; i < 6; i++)
      send(12'($urandom_range(0, 4095)), i == 0, i == 5, 3'd4);
    drain("gray_frame");
  endtask

  task automatic test_pink();
    for (int i = 0; i < 20; i++) strobe(1000);
    total++;
    if (int'(dut.u_pitch.p_s_q) != 63) begin bad++; $display("FAIL pink_p_s: got %0d want 63", dut.u_pitch.p_s_q); end
    send(12'hF00, 1'b1, 1'b1, 3'd1);
    wait_out("pink_max", {10'd470, 10'd117, 10'd235});
    drain("pink");
  endtask

  task automatic test_modes();
    for (int m = 0; m < 8; m++) begin
      strobe(10 + m * 7);
      for (int i = 0; i < 4; i++)
        send(12'($urandom_range(0, 4095)), i == 0, i == 3, 3'(m));
      send(12'hFFF, 1'b1, 1'b0, 3'(m));
      send(12'h000, 1'b0, 1'b1, 3'(m));
    end
    drain("modes");
  endtask

  task automatic test_frame_latch();
    send(12'h123, 1'b1, 1'b0, 3'd0);
    send(12'h456, 1'b0, 1'b0, 3'd3);
    send(12'h789, 1'b0, 1'b1, 3'd3);
    send(12'h8A1, 1'b1, 1'b1, 3'd3);
    drain("frame_latch");
  endtask

  task automatic test_pitch_with_sop();
    for (int i = 0; i < 20; i++) strobe(0);
    pitch_in = 30'd63; pitch_valid = 1'b1;
    send(12'hFC3, 1'b1, 1'b0, 3'd1);
    pitch_valid = 1'b0;
    send(12'hFC3, 1'b0, 1'b1, 3'd1);
    send(12'hFC3, 1'b1, 1'b1, 3'd1);
    drain("pitch_with_sop");
  endtask

  task automatic test_backpressure();
    int start_pops;
    start_pops = pops;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(12'($urandom_range(0, 4095)), i == 0, i == 9, 3'd5);
      end
      begin
        for (int c = 0; c < 20; c++) begin
          m_ready = !(c >= 4 && c <= 8);
          @(posedge clk); #1;
        end
        m_ready = 1'b1;
      end
    join
    drain("backpressure");
    total++;
    if (pops - start_pops != 10) begin
      bad++;
      $display("FAIL backpressure_count: got %0d want 10", pops - start_pops);
    end
  endtask

  task automatic test_smoothing();
    for (int i = 0; i < 20; i++) strobe(0);
    strobe(0);
    total++;
    if (int'(dut.u_pitch.p_s_q) != m_ps || m_ps != 10) begin
      bad++; $display("FAIL smooth_floor: got %0d want 10", dut.u_pitch.p_s_q);
    end
    strobe(12);
    total++;
    if (int'(dut.u_pitch.p_s_q) != m_ps) begin
      bad++; $display("FAIL smooth_snap: got %0d want %0d", dut.u_pitch.p_s_q, m_ps);
    end
    strobe(50);
    total++;
    if (int'(dut.u_pitch.p_s_q) != m_ps) begin
      bad++; $display("FAIL smooth_step: got %0d want %0d", dut.u_pitch.p_s_q, m_ps);
    end
    send(12'hFFF, 1'b1, 1'b1, 3'd1);
    drain("smooth_pink");
  endtask

  task automatic test_reset_midframe();
    send(12'h111, 1'b1, 1'b0, 3'd5);
    send(12'h222, 1'b0, 1'b0, 3'd5);
    send(12'h333, 1'b0, 1'b0, 3'd5);
    #2 rst_n = 1'b0;
    #1;
    total += 2;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL midreset_m_valid: got %b want 0", m_valid); end
    if (m_data !== 30'd0) begin bad++; $display("FAIL midreset_m_data: got %h want 0", m_data); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    s_data = 12'hF0F; s_sop = 1'b0; s_eop = 1'b1; filter_selection = 3'd5; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; s_eop = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      total++;
      if (m_valid !== (k == 3)) begin
        bad++; $display("FAIL midreset_latency_edge%0d: got %b want %b", k, m_valid, (k == 3));
      end
      if (k < 3) begin
        @(posedge clk); #1;
      end
    end
    drain("midreset");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_gray();
    test_pink();
    test_modes();
    test_frame_latch();
    test_pitch_with_sop();
    test_backpressure();
    test_smoothing();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
